// File: rtl/rename_freelist_if.sv
// rename_freelist_if
//   Bundles the rename-side and commit-side signals of the physical register
//   free list so they can be passed around as a single port.
//
//   Handshake: alloc_ready_o is the ready, alloc_req_i the per-slot valid.
//   A slot's tag is consumed on a cycle where its alloc_req_i bit is set,
//   alloc_ready_o is high and flush_i is low. Requests while
//   alloc_ready_o is low are ignored. Release and commit have no
//   back-pressure and are taken every cycle they are asserted.
//
//   master: the rename/commit logic driving requests.
//   slave : the free list itself.
interface rename_freelist_if #(
  parameter int PREG_WIDTH = 6,
  parameter int PTR_WIDTH  = 6
);
  logic [1:0]                 alloc_req_i;
  logic                       alloc_ready_o;
  logic [1:0][PREG_WIDTH-1:0] alloc_preg_o;
  logic [1:0]                 commit_alloc_i;
  logic [1:0]                 release_we_i;
  logic [1:0][PREG_WIDTH-1:0] release_preg_i;
  logic                       flush_i;
  logic [PTR_WIDTH-1:0]       free_count_o;

  modport master (
    output alloc_req_i, commit_alloc_i, release_we_i, release_preg_i, flush_i,
    input  alloc_ready_o, alloc_preg_o, free_count_o
  );

  modport slave (
    input  alloc_req_i, commit_alloc_i, release_we_i, release_preg_i, flush_i,
    output alloc_ready_o, alloc_preg_o, free_count_o
  );
endinterface

// File: rtl/rename_freelist.sv
// rename_freelist
//   Circular free list of physical register tags for a 2-wide rename stage.
//   Offers two tags per cycle, takes back up to two superseded tags at
//   commit, and tracks a committed head so a flush returns every
//   speculatively allocated tag in a single cycle.
//
//   Ports:
//     clk : clock
//     rst : asynchronous active-high reset
//     fl  : rename_freelist_if.slave (alloc, commit, release, flush, count)
module rename_freelist #(
  parameter int PHYS_COUNT = 64,
  parameter int ARCH_COUNT = 32
) (
  input  logic              clk,
  input  logic              rst,
  rename_freelist_if.slave  fl
);
  localparam int DEPTH      = PHYS_COUNT - ARCH_COUNT;
  localparam int PREG_WIDTH = $clog2(PHYS_COUNT);
  localparam int PTR_WIDTH  = $clog2(DEPTH) + 1;
  localparam int IDX_W      = PTR_WIDTH - 1;

  logic [PREG_WIDTH-1:0] entries [DEPTH];
  logic [PTR_WIDTH-1:0]  head;
  logic [PTR_WIDTH-1:0]  tail;
  logic [PTR_WIDTH-1:0]  commit_head;
  logic [PTR_WIDTH-1:0]  commit_head_nxt;
  logic [PTR_WIDTH-1:0]  count;
  logic                  alloc_ready;
  logic [IDX_W-1:0]      head_idx0;
  logic [IDX_W-1:0]      head_idx1;
  logic [IDX_W-1:0]      tail_idx0;
  logic [IDX_W-1:0]      tail_idx1;

  function automatic logic [PTR_WIDTH-1:0] pop2(input logic [1:0] v);
    return PTR_WIDTH'(v[0]) + PTR_WIDTH'(v[1]);
  endfunction

  // Pointers carry one extra wrap bit, so the subtraction gives the
  // occupancy directly, including the full case (count == DEPTH).
  assign count       = tail - head;
  assign alloc_ready = (count >= PTR_WIDTH'(2));

  // Slot 1 takes the entry after slot 0 only when slot 0 also requests,
  // so a lone slot-1 request is served from head.
  assign head_idx0 = head[IDX_W-1:0];
  assign head_idx1 = head[IDX_W-1:0] + IDX_W'(fl.alloc_req_i[0]);
  assign tail_idx0 = tail[IDX_W-1:0];
  assign tail_idx1 = tail[IDX_W-1:0] + IDX_W'(fl.release_we_i[0]);

  assign commit_head_nxt = commit_head + pop2(fl.commit_alloc_i);

  always_comb begin
    fl.alloc_preg_o[0] = entries[head_idx0];
    fl.alloc_preg_o[1] = entries[head_idx1];
  end

  assign fl.alloc_ready_o = alloc_ready;
  assign fl.free_count_o  = count;

  // At reset the architectural registers own tags 0..ARCH_COUNT-1, so the
  // list holds the remaining tags in ascending order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= PREG_WIDTH'(ARCH_COUNT + i);
      end
    end else begin
      if (fl.release_we_i[0]) entries[tail_idx0] <= fl.release_preg_i[0];
      if (fl.release_we_i[1]) entries[tail_idx1] <= fl.release_preg_i[1];
    end
  end

  // Flush rewinds head to the committed point including this cycle's
  // commits; any allocation in the same cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= PTR_WIDTH'(DEPTH);
      commit_head <= '0;
    end else begin
      commit_head <= commit_head_nxt;
      tail        <= tail + pop2(fl.release_we_i);
      if (fl.flush_i) begin
        head <= commit_head_nxt;
      end else if (alloc_ready) begin
        head <= head + pop2(fl.alloc_req_i);
      end
    end
  end
endmodule

// File: tb/tb_rename_freelist.sv
module tb_rename_freelist;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] exp_q[$];

  // reference model of the free list
  int m_ent [32];
  int m_head;
  int m_tail;
  int m_chead;

  rename_freelist_if #(.PREG_WIDTH(6), .PTR_WIDTH(6)) bus ();

  rename_freelist #(.PHYS_COUNT(64), .ARCH_COUNT(32)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_count();
    return (m_tail - m_head) & 63;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_ent[i] = 32 + i;
    m_head  = 0;
    m_tail  = 32;
    m_chead = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alloc_req_i       = 2'b11;
    bus.commit_alloc_i    = 2'b00;
    bus.release_we_i      = 2'b00;
    bus.release_preg_i[0] = '0;
    bus.release_preg_i[1] = '0;
    bus.flush_i           = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // driver: one cycle of stimulus, scoreboard compare of the offer, model update
  task automatic step(input logic [1:0] req, input logic [1:0] cm, input logic [1:0] rw,
                      input int r0, input int r1, input logic fl_in);
    logic rdy;
    bus.alloc_req_i       = req;
    bus.commit_alloc_i    = cm;
    bus.release_we_i      = rw;
    bus.release_preg_i[0] = 6'(r0);
    bus.release_preg_i[1] = 6'(r1);
    bus.flush_i           = fl_in;
    #1;
    exp_q.push_back(32'(m_ent[m_head % 32]));
    exp_q.push_back(32'(m_ent[(m_head + int'(req[0])) % 32]));
    exp_q.push_back(32'(m_count() >= 2));
    exp_q.push_back(32'(m_count()));
    chk("offer0", 32'(bus.alloc_preg_o[0]), exp_q.pop_front());
    chk("offer1", 32'(bus.alloc_preg_o[1]), exp_q.pop_front());
    chk("ready",  32'(bus.alloc_ready_o),   exp_q.pop_front());
    chk("count",  32'(bus.free_count_o),    exp_q.pop_front());
    @(posedge clk);
    rdy = (m_count() >= 2);
    if (rw[0]) m_ent[m_tail % 32] = r0;
    if (rw[1]) m_ent[(m_tail + int'(rw[0])) % 32] = r1;
    m_tail  = (m_tail + int'(rw[0]) + int'(rw[1])) & 63;
    m_chead = (m_chead + int'(cm[0]) + int'(cm[1])) & 63;
    if (fl_in) m_head = m_chead;
    else if (rdy) m_head = (m_head + int'(req[0]) + int'(req[1])) & 63;
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  initial begin
    int spec, ncm, nrel, base, room, r0, r1;
    logic [1:0] req, cm, rw;
    logic fl_r;
    checks   = 0;
    failures = 0;

    // 1: reset state, then one 2-wide allocation
    do_reset();
    chk("rst_offer0", 32'(bus.alloc_preg_o[0]), 32);
    chk("rst_offer1", 32'(bus.alloc_preg_o[1]), 33);
    chk("rst_count",  32'(bus.free_count_o), 32);
    chk("rst_ready",  32'(bus.alloc_ready_o), 1);
    step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    chk("a2_offer0", 32'(bus.alloc_preg_o[0]), 34);
    chk("a2_offer1", 32'(bus.alloc_preg_o[1]), 35);
    chk("a2_count",  32'(bus.free_count_o), 30);

    // 2: compaction, then exhaustion
    do_reset();
    bus.alloc_req_i = 2'b10;
    #1;
    chk("compact_slot1", 32'(bus.alloc_preg_o[1]), 32);
    step(2'b10, 2'b00, 2'b00, 0, 0, 1'b0);
    chk("compact_head", 32'(bus.alloc_preg_o[0]), 33);
    chk("compact_count", 32'(bus.free_count_o), 31);
    while (m_count() >= 2) step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    chk("exh_ready", 32'(bus.alloc_ready_o), 0);
    chk("exh_count", 32'(bus.free_count_o), 1);
    step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    chk("exh_hold_count", 32'(bus.free_count_o), 1);
    chk("exh_hold_offer", 32'(bus.alloc_preg_o[0]), 63);

    // 3: release into an empty list at tail index 0
    do_reset();
    for (int i = 0; i < 16; i++) step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    chk("empty_count", 32'(bus.free_count_o), 0);
    chk("empty_ready", 32'(bus.alloc_ready_o), 0);
    step(2'b00, 2'b00, 2'b11, 5, 7, 1'b0);
    chk("rel_count",  32'(bus.free_count_o), 2);
    chk("rel_ready",  32'(bus.alloc_ready_o), 1);
    chk("rel_offer0", 32'(bus.alloc_preg_o[0]), 5);
    chk("rel_offer1", 32'(bus.alloc_preg_o[1]), 7);

    // 4: flush recovery
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    step(2'b00, 2'b11, 2'b00, 0, 0, 1'b0);
    step(2'b00, 2'b00, 2'b00, 0, 0, 1'b1);
    chk("flush_count",  32'(bus.free_count_o), 30);
    chk("flush_offer0", 32'(bus.alloc_preg_o[0]), 34);
    chk("flush_offer1", 32'(bus.alloc_preg_o[1]), 35);

    // 5: flush + commit + release + alloc in one cycle
    step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    step(2'b11, 2'b01, 2'b01, 3, 0, 1'b1);
    chk("combo_count",  32'(bus.free_count_o), 30);
    chk("combo_offer0", 32'(bus.alloc_preg_o[0]), 35);

    // random legal traffic against the model
    for (int it = 0; it < 300; it++) begin
      req  = 2'($urandom_range(0, 3));
      spec = (m_head - m_chead) & 63;
      ncm  = $urandom_range(0, (spec < 2) ? spec : 2);
      cm   = (ncm == 2) ? 2'b11 : (ncm == 1) ? (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01) : 2'b00;
      fl_r = ($urandom_range(0, 15) == 0);
      if (fl_r) base = (m_tail - ((m_chead + ncm) & 63)) & 63;
      else if (m_count() >= 2) base = m_count() - int'(req[0]) - int'(req[1]);
      else base = m_count();
      room = 32 - base;
      nrel = $urandom_range(0, (room < 2) ? room : 2);
      rw   = (nrel == 2) ? 2'b11 : (nrel == 1) ? (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01) : 2'b00;
      r0   = $urandom_range(0, 63);
      r1   = $urandom_range(0, 63);
      step(req, cm, rw, r0, r1, fl_r);
    end

    // 6: asynchronous reset between clock edges
    for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    bus.alloc_req_i = 2'b11;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_offer0", 32'(bus.alloc_preg_o[0]), 32);
    chk("arst_offer1", 32'(bus.alloc_preg_o[1]), 33);
    chk("arst_count",  32'(bus.free_count_o), 32);
    chk("arst_ready",  32'(bus.alloc_ready_o), 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    step(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    chk("post_arst_offer0", 32'(bus.alloc_preg_o[0]), 34);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
